// File: rtl/rgb_pwm_core.sv
// Three-channel PWM LED driver fed from the rgb AXI4-Lite register bank.
// Double-buffered duty, prescaled PWM counter, period-counted blink sequencer.
module rgb_pwm_core #(
    parameter int unsigned PWM_BITS   = 8,
    parameter int unsigned PRESC_BITS = 16,
    parameter bit          ACTIVE_LOW = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] ctrl_i,
    input  logic [31:0] duty_i,
    input  logic [31:0] prescale_i,
    input  logic [31:0] blink_i,
    output logic        led_r_o,
    output logic        led_g_o,
    output logic        led_b_o,
    output logic        period_tick_o,
    output logic [31:0] status_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } blink_state_t;

    blink_state_t state, state_nxt;
    logic [15:0]  bcnt, bcnt_nxt;

    logic [PRESC_BITS-1:0] presc_cnt;
    logic [PWM_BITS-1:0]   pwm_cnt;
    logic [PWM_BITS-1:0]   shadow_r, shadow_g, shadow_b;
    logic                  shadow_valid;

    logic enable, blink_en, force_upd;
    logic [PRESC_BITS-1:0] presc_max;
    logic [15:0] on_len, off_len;
    logic running, step, period_end, blink_act;
    logic raw_r, raw_g, raw_b, blink_on;
    logic [7:0] cnt_low;
    logic unused_bits;

    assign enable    = ctrl_i[0];
    assign blink_en  = ctrl_i[1];
    assign force_upd = ctrl_i[2];
    assign presc_max = prescale_i[PRESC_BITS-1:0];
    assign on_len    = blink_i[15:0];
    assign off_len   = blink_i[31:16];
    assign unused_bits = ^{ctrl_i[31:3], duty_i[31:3*PWM_BITS], prescale_i[31:PRESC_BITS]};

    // Counters hold for the single IDLE->ON cycle so a restart begins at pwm_cnt=0 in ON.
    assign running    = enable && (state != ST_IDLE);
    assign step       = running && (presc_cnt == presc_max);
    assign period_end = step && (pwm_cnt == '1);
    assign blink_act  = blink_en && (on_len != 16'd0) && (off_len != 16'd0);

    always_ff @(posedge clock) begin
        if (reset || !enable) begin
            presc_cnt     <= '0;
            pwm_cnt       <= '0;
            period_tick_o <= 1'b0;
        end else begin
            period_tick_o <= period_end;
            if (running)
                presc_cnt <= step ? '0 : presc_cnt + 1'b1;
            if (step)
                pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            shadow_r     <= '0;
            shadow_g     <= '0;
            shadow_b     <= '0;
            shadow_valid <= 1'b0;
        end else if (period_end || !enable || force_upd) begin
            shadow_r     <= duty_i[0 +: PWM_BITS];
            shadow_g     <= duty_i[PWM_BITS +: PWM_BITS];
            shadow_b     <= duty_i[2*PWM_BITS +: PWM_BITS];
            shadow_valid <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
            bcnt  <= '0;
        end else begin
            state <= state_nxt;
            bcnt  <= bcnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        bcnt_nxt  = bcnt;
        if (!enable) begin
            state_nxt = ST_IDLE;
            bcnt_nxt  = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_nxt = ST_ON;
                    bcnt_nxt  = '0;
                end
                ST_ON: if (period_end) begin
                    if (!blink_act) begin
                        bcnt_nxt = '0;
                    end else if (bcnt == on_len - 16'd1) begin
                        state_nxt = ST_OFF;
                        bcnt_nxt  = '0;
                    end else begin
                        bcnt_nxt = bcnt + 16'd1;
                    end
                end
                ST_OFF: if (period_end) begin
                    if (!blink_act || bcnt == off_len - 16'd1) begin
                        state_nxt = ST_ON;
                        bcnt_nxt  = '0;
                    end else begin
                        bcnt_nxt = bcnt + 16'd1;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    bcnt_nxt  = '0;
                end
            endcase
        end
    end

    assign blink_on = (state == ST_ON);
    assign raw_r    = (pwm_cnt < shadow_r);
    assign raw_g    = (pwm_cnt < shadow_g);
    assign raw_b    = (pwm_cnt < shadow_b);

    always_ff @(posedge clock) begin
        if (reset) begin
            led_r_o <= ACTIVE_LOW;
            led_g_o <= ACTIVE_LOW;
            led_b_o <= ACTIVE_LOW;
        end else begin
            led_r_o <= (enable && blink_on && raw_r) ^ ACTIVE_LOW;
            led_g_o <= (enable && blink_on && raw_g) ^ ACTIVE_LOW;
            led_b_o <= (enable && blink_on && raw_b) ^ ACTIVE_LOW;
        end
    end

    assign cnt_low = 8'(pwm_cnt);

    always_comb begin
        status_o       = '0;
        status_o[7:0]  = cnt_low;
        status_o[9:8]  = state;
        status_o[10]   = shadow_valid;
    end

endmodule

// File: tb/tb_rgb_pwm_core.sv
// Directed self-checking bench for rgb_pwm_core: reset, duty, prescale,
// double-buffering, force update, blink sequencing and disable/reset.
module tb_rgb_pwm_core;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] ctrl, duty, presc, blink;
    logic        led_r_o, led_g_o, led_b_o, period_tick_o;
    logic [31:0] status_o;

    int total = 0;
    int bad   = 0;
    int r, g, b, t, n;
    int exp_st[10] = '{1, 2, 2, 2, 1, 1, 2, 2, 2, 1};

    always #5 clock = ~clock;

    rgb_pwm_core #(
        .PWM_BITS  (8),
        .PRESC_BITS(16),
        .ACTIVE_LOW(1'b0)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .ctrl_i       (ctrl),
        .duty_i       (duty),
        .prescale_i   (presc),
        .blink_i      (blink),
        .led_r_o      (led_r_o),
        .led_g_o      (led_g_o),
        .led_b_o      (led_b_o),
        .period_tick_o(period_tick_o),
        .status_o     (status_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_tick(input int budget, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clock);
            if (period_tick_o) seen = 1'b1;
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    task automatic measure(input int len, output int cr, output int cg, output int cb, output int ct);
        cr = 0; cg = 0; cb = 0; ct = 0;
        for (int i = 0; i < len; i++) begin
            @(negedge clock);
            cr += int'(led_r_o);
            cg += int'(led_g_o);
            cb += int'(led_b_o);
            ct += int'(period_tick_o);
        end
    endtask

    task automatic gap(output int cyc);
        bit seen = 1'b0;
        cyc = 0;
        for (int i = 0; i < 5000 && !seen; i++) begin
            @(negedge clock);
            cyc++;
            if (period_tick_o) seen = 1'b1;
        end
    endtask

    initial begin
        reset = 1'b1; ctrl = '0; duty = '0; presc = '0; blink = '0;
        repeat (5) @(negedge clock);
        chk("rst_leds",   {29'd0, led_r_o, led_g_o, led_b_o}, 32'd0);
        chk("rst_status", status_o, 32'd0);
        chk("rst_tick",   32'(period_tick_o), 32'd0);

        // steady PWM, P=0
        duty = 32'h00FF_0040; ctrl = 32'd1; reset = 1'b0;
        wait_tick(600, "t2_first_tick");
        measure(256, r, g, b, t);
        chk("t2_r_high", r, 64);
        chk("t2_g_high", g, 0);
        chk("t2_b_high", b, 255);
        chk("t2_ticks",  t, 1);
        gap(n);
        chk("t2_tick_gap", n, 256);

        // prescaler P=3
        presc = 32'd3; duty = 32'h00FF_0080;
        wait_tick(2000, "t3_tick_a");
        wait_tick(2000, "t3_tick_b");
        measure(1024, r, g, b, t);
        chk("t3_r_high", r, 512);
        chk("t3_b_high", b, 1020);
        chk("t3_ticks",  t, 1);
        gap(n);
        chk("t3_tick_gap", n, 1024);

        // mid-period duty write is deferred to next period
        presc = 32'd0; duty = 32'h0000_0010;
        wait_tick(2000, "t4_tick_a");
        wait_tick(600,  "t4_tick_b");
        r = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clock);
            if (i == 100) duty = 32'h0000_00F0;
            r += int'(led_r_o);
        end
        chk("t4_cur_period", r, 16);
        chk("t4_tick_end", 32'(period_tick_o), 32'd1);
        measure(256, r, g, b, t);
        chk("t4_next_period", r, 240);

        // force_update takes effect within 2 clocks
        repeat (100) @(negedge clock);
        chk("t4_force_pre", 32'(led_r_o), 32'd1);
        duty = 32'h0000_0010; ctrl = 32'd5;
        repeat (2) @(negedge clock);
        chk("t4_force_post", 32'(led_r_o), 32'd0);

        // blink on=2 off=3
        duty = 32'h0000_00FF; blink = {16'd3, 16'd2}; ctrl = 32'd3;
        wait_tick(600, "t5_first_tick");
        chk("t5_state0", {30'd0, status_o[9:8]}, 32'(exp_st[0]));
        for (int p = 0; p < 9; p++) begin
            measure(256, r, g, b, t);
            chk($sformatf("t5_r_period%0d", p), r, (exp_st[p] == 1) ? 255 : 0);
            chk($sformatf("t5_tick%0d", p), t, 1);
            chk($sformatf("t5_state%0d", p + 1), {30'd0, status_o[9:8]}, 32'(exp_st[p + 1]));
        end

        // disable + reset during ON high phase, then re-enable
        ctrl = 32'd1;
        repeat (20) @(negedge clock);
        chk("t6_high_before", 32'(led_r_o), 32'd1);
        ctrl = 32'd0; reset = 1'b1;
        @(negedge clock);
        chk("t6_leds_off",  {29'd0, led_r_o, led_g_o, led_b_o}, 32'd0);
        chk("t6_status",    status_o, 32'd0);
        chk("t6_tick",      32'(period_tick_o), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        chk("t6_idle_status", status_o, 32'h0000_0400);
        ctrl = 32'd1;
        @(negedge clock);
        chk("t6_restart_on", status_o, 32'h0000_0500);
        @(negedge clock);
        chk("t6_restart_cnt", status_o, 32'h0000_0501);
        chk("t6_restart_led", 32'(led_r_o), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
